// File: rtl/vga_tape_scanout_if.sv
// rtl/vga_tape_scanout_if.sv - tape RAM read port and VGA video output bundle
interface vga_tape_scanout_if #(
    parameter int ADDR_W  = 14,
    parameter int COLOR_W = 4
);
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_data;
    logic               vga_h_sync;
    logic               vga_v_sync;
    logic               vga_de;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               frame_start;

    modport master (
        output mem_addr,
        input  mem_data,
        output vga_h_sync, vga_v_sync, vga_de, r, g, b, frame_start
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  vga_h_sync, vga_v_sync, vga_de, r, g, b, frame_start
    );
endinterface

// File: rtl/vga_tape_scanout.sv
// rtl/vga_tape_scanout.sv - parametrised VGA scan-out of the tape cell memory
module vga_tape_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CELL_SHIFT = 3,
    parameter int COLS_W     = 7,
    parameter int ADDR_W     = 14,
    parameter int MEM_LAT    = 1,
    parameter int COLOR_W    = 4
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              cursor_en,
    input  logic [ADDR_W-1:0] cursor_addr,
    input  logic              grid_en,
    vga_tape_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [31:0] COL_MASK  = (32'd1 << COLS_W) - 32'd1;
    localparam logic [31:0] CELL_MASK = (32'd1 << CELL_SHIFT) - 32'd1;

    // Per-pixel attributes that travel alongside the RAM read so they stay aligned.
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       ovf;
        logic       grid;
        logic       cur;
        logic [1:0] mode;
        logic [6:0] pat_x;
        logic [3:0] pat_y;
    } pix_t;

    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [1:0]        mode_l;
    logic              cursor_en_l;
    logic [ADDR_W-1:0] cursor_addr_l;
    logic              grid_en_l;
    pix_t              pipe [MEM_LAT+1];

    logic              fs;
    logic [31:0]       hx, vy, col, row;
    logic [ADDR_W-1:0] cell_addr;
    logic [1:0]        e_mode;
    logic              e_cen, e_grid;
    logic [ADDR_W-1:0] e_caddr;
    pix_t              cur_pix;
    pix_t              p;
    logic [COLOR_W-1:0] c_r, c_g, c_b;

    function automatic logic [COLOR_W-1:0] fit(input logic [3:0] v);
        return COLOR_W'(v);
    endfunction

    assign fs              = !reset && (hcnt == '0) && (vcnt == '0);
    assign bus.frame_start = fs;

    // Settings sampled in the frame_start cycle already apply to pixel (0,0).
    assign e_mode  = fs ? mode        : mode_l;
    assign e_cen   = fs ? cursor_en   : cursor_en_l;
    assign e_caddr = fs ? cursor_addr : cursor_addr_l;
    assign e_grid  = fs ? grid_en     : grid_en_l;

    always_comb begin
        hx        = 32'(hcnt);
        vy        = 32'(vcnt);
        col       = hx >> CELL_SHIFT;
        row       = vy >> CELL_SHIFT;
        cell_addr = ADDR_W'((row << COLS_W) | (col & COL_MASK));

        cur_pix        = '0;
        cur_pix.active = (hx < H_ACTIVE) && (vy < V_ACTIVE);
        cur_pix.hs     = (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
        cur_pix.vs     = (vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC);
        cur_pix.ovf    = (col >> COLS_W) != 32'd0;
        cur_pix.grid   = e_grid && (((hx & CELL_MASK) == 32'd0) || ((vy & CELL_MASK) == 32'd0));
        cur_pix.cur    = e_cen && (cell_addr == e_caddr);
        cur_pix.mode   = e_mode;
        cur_pix.pat_x  = 7'(hx >> 2);
        cur_pix.pat_y  = 4'(vy >> 2);
    end

    assign p = pipe[MEM_LAT];

    always_comb begin
        c_r = '0;
        c_g = '0;
        c_b = '0;
        case (p.mode)
            2'd0: begin
                c_r = fit(bus.mem_data[7:4]);
                c_g = fit(bus.mem_data[3:0]);
            end
            2'd1: begin
                c_r = fit(bus.mem_data[7:4]);
                c_g = fit(bus.mem_data[7:4]);
                c_b = fit(bus.mem_data[7:4]);
            end
            2'd2: begin
                if (bus.mem_data != 8'd0) begin
                    c_r = '1;
                    c_g = '1;
                    c_b = '1;
                end else begin
                    c_b = COLOR_W'(2);
                end
            end
            default: begin
                c_r = fit(p.pat_x[3:0]);
                c_g = fit(p.pat_y);
                c_b = fit(p.pat_x[6:3]);
            end
        endcase
        if (p.cur) begin
            c_r = ~c_r;
            c_g = ~c_g;
            c_b = ~c_b;
        end
        // Overflow columns are forced black so they never alias onto the next row.
        if (!p.active || p.ovf) begin
            c_r = '0;
            c_g = '0;
            c_b = '0;
        end else if (p.grid) begin
            c_r = COLOR_W'(2);
            c_g = COLOR_W'(2);
            c_b = COLOR_W'(2);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hcnt           <= '0;
            vcnt           <= '0;
            bus.mem_addr   <= '0;
            mode_l         <= '0;
            cursor_en_l    <= 1'b0;
            cursor_addr_l  <= '0;
            grid_en_l      <= 1'b0;
            for (int i = 0; i <= MEM_LAT; i++) pipe[i] <= '0;
            bus.vga_de     <= 1'b0;
            bus.vga_h_sync <= ~SYNC_POL;
            bus.vga_v_sync <= ~SYNC_POL;
            bus.r          <= '0;
            bus.g          <= '0;
            bus.b          <= '0;
        end else begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
            if (fs) begin
                mode_l        <= mode;
                cursor_en_l   <= cursor_en;
                cursor_addr_l <= cursor_addr;
                grid_en_l     <= grid_en;
            end
            bus.mem_addr <= cell_addr;
            pipe[0]      <= cur_pix;
            for (int i = 1; i <= MEM_LAT; i++) pipe[i] <= pipe[i-1];
            bus.vga_de     <= p.active;
            bus.vga_h_sync <= p.hs ? SYNC_POL : ~SYNC_POL;
            bus.vga_v_sync <= p.vs ? SYNC_POL : ~SYNC_POL;
            bus.r          <= c_r;
            bus.g          <= c_g;
            bus.b          <= c_b;
        end
    end
endmodule
